// File: rtl/pre_if_pc_gen.sv
// Pre-IF stage: owns the fetch PC, issues fetch addresses to the I-cache
// CPU bus and arbitrates redirects (flush > buffered > branch > jump).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_REQ  | address on the bus (unless misaligned), waiting for addr_ok
// S_HOLD | address accepted by the cache, waiting for IF to take the PC
module pre_if_pc_gen #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            IF_Wr,
  input  logic            exc_flush,
  input  logic [PC_W-1:0] exc_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  output logic            ibus_req,
  output logic [PC_W-1:0] ibus_addr,
  input  logic            ibus_addr_ok,
  output logic [PC_W-1:0] PREIF_PC,
  output logic            PREIF_ExceptType
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_v, pend_v_d;
  logic [PC_W-1:0] pend_target, pend_target_d;

  logic mis;
  logic done;
  logic advance;

  assign mis              = (pc_q[1:0] != 2'b00);
  assign PREIF_ExceptType = mis;
  assign PREIF_PC         = pc_q;
  assign ibus_addr        = pc_q;

  // The request is gated by reset itself so it drops without waiting for an edge.
  assign ibus_req = resetn & (state_q == S_REQ) & ~mis;

  // A misaligned PC never goes to the bus, so it counts as done immediately.
  assign done    = mis | ((state_q == S_REQ) & ibus_addr_ok) | (state_q == S_HOLD);
  assign advance = done & IF_Wr;

  // Next PC, state and redirect buffer.
  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    pend_v_d      = pend_v;
    pend_target_d = pend_target;

    if (exc_flush) begin
      pc_d     = exc_target;
      state_d  = S_REQ;
      pend_v_d = 1'b0;
    end else if (advance) begin
      state_d  = S_REQ;
      pend_v_d = 1'b0;
      if (pend_v) begin
        pc_d = pend_target;
      end else if (branch_taken) begin
        pc_d = branch_target;
      end else if (jump_taken) begin
        pc_d = jump_target;
      end else begin
        pc_d = pc_q + PC_W'(4);
      end
    end else begin
      if ((state_q == S_REQ) && ibus_addr_ok && !IF_Wr) begin
        state_d = S_HOLD;
      end
      // A buffered jump may be replaced by a branch, never the other way round.
      if (branch_taken) begin
        pend_v_d      = 1'b1;
        pend_target_d = branch_target;
      end else if (jump_taken && !pend_v) begin
        pend_v_d      = 1'b1;
        pend_target_d = jump_target;
      end
    end
  end

  // State, PC and redirect buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pend_v      <= 1'b0;
      pend_target <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v      <= pend_v_d;
      pend_target <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pre_if_pc_gen.sv
// Directed bench for pre_if_pc_gen.
module tb_pre_if_pc_gen;

  logic        clk;
  logic        resetn;
  logic        IF_Wr;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic [31:0] PREIF_PC;
  logic        PREIF_ExceptType;

  int n_checks = 0;
  int n_errors = 0;

  pre_if_pc_gen #(.PC_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .IF_Wr            (IF_Wr),
    .exc_flush        (exc_flush),
    .exc_target       (exc_target),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump_taken       (jump_taken),
    .jump_target      (jump_target),
    .ibus_req         (ibus_req),
    .ibus_addr        (ibus_addr),
    .ibus_addr_ok     (ibus_addr_ok),
    .PREIF_PC         (PREIF_PC),
    .PREIF_ExceptType (PREIF_ExceptType)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn        = 1'b0;
    IF_Wr         = 1'b0;
    exc_flush     = 1'b0;
    exc_target    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump_taken    = 1'b0;
    jump_target   = '0;
    ibus_addr_ok  = 1'b0;

    #12;
    chk("rst_pc",   PREIF_PC, 32'hBFC0_0000);
    chk("rst_addr", ibus_addr, 32'hBFC0_0000);
    chk("rst_req",  32'(ibus_req), 32'd0);
    chk("rst_exc",  32'(PREIF_ExceptType), 32'd0);
    chk("rst_pend", 32'(dut.pend_v), 32'd0);

    // Streaming fetch
    resetn = 1'b1; ibus_addr_ok = 1'b1; IF_Wr = 1'b1;
    #1;
    chk("seq0_addr", ibus_addr, 32'hBFC0_0000);
    chk("seq0_req",  32'(ibus_req), 32'd1);
    step();
    chk("seq1_addr", ibus_addr, 32'hBFC0_0004);
    chk("seq1_req",  32'(ibus_req), 32'd1);
    step();
    chk("seq2_addr", ibus_addr, 32'hBFC0_0008);
    step();
    step();
    chk("seq4_addr", ibus_addr, 32'hBFC0_0010);

    // Stall without handshake, then handshake without IF write, then hold
    ibus_addr_ok = 1'b0; IF_Wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",  32'(ibus_req), 32'd1);
      chk("stall_addr", ibus_addr, 32'hBFC0_0010);
      step();
    end
    ibus_addr_ok = 1'b1;
    chk("hs_req", 32'(ibus_req), 32'd1);
    step();
    ibus_addr_ok = 1'b0;
    chk("hold0_req",  32'(ibus_req), 32'd0);
    chk("hold0_addr", ibus_addr, 32'hBFC0_0010);
    step();
    chk("hold1_req", 32'(ibus_req), 32'd0);
    IF_Wr = 1'b1;
    step();
    chk("hold_adv_addr", ibus_addr, 32'hBFC0_0014);
    chk("hold_adv_req",  32'(ibus_req), 32'd1);

    // Branch during stall is buffered
    ibus_addr_ok = 1'b0; IF_Wr = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h8000_1000;
    step();
    branch_taken = 1'b0;
    chk("buf_pend", 32'(dut.pend_v), 32'd1);
    chk("buf_addr", ibus_addr, 32'hBFC0_0014);
    ibus_addr_ok = 1'b1; IF_Wr = 1'b1;
    step();
    chk("buf_adv_addr", ibus_addr, 32'h8000_1000);
    chk("buf_adv_pend", 32'(dut.pend_v), 32'd0);

    // Buffered jump replaced by branch; later jump does not replace it
    ibus_addr_ok = 1'b0; IF_Wr = 1'b0;
    jump_taken = 1'b1; jump_target = 32'h8000_4000;
    step();
    jump_taken = 1'b0; branch_taken = 1'b1; branch_target = 32'h8000_6000;
    step();
    branch_taken = 1'b0; jump_taken = 1'b1; jump_target = 32'h8000_5000;
    step();
    jump_taken = 1'b0;
    chk("ovr_pend", 32'(dut.pend_v), 32'd1);
    ibus_addr_ok = 1'b1; IF_Wr = 1'b1;
    step();
    chk("ovr_addr", ibus_addr, 32'h8000_6000);

    // Flush beats everything, including a buffered redirect
    ibus_addr_ok = 1'b0; IF_Wr = 1'b0;
    jump_taken = 1'b1; jump_target = 32'h8000_4000;
    step();
    chk("fl_pend_pre", 32'(dut.pend_v), 32'd1);
    jump_target = 32'h8000_3000;
    branch_taken = 1'b1; branch_target = 32'h8000_2000;
    exc_flush = 1'b1; exc_target = 32'hBFC0_0380;
    step();
    exc_flush = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    chk("fl_addr", ibus_addr, 32'hBFC0_0380);
    chk("fl_pend", 32'(dut.pend_v), 32'd0);
    chk("fl_req",  32'(ibus_req), 32'd1);
    ibus_addr_ok = 1'b1; IF_Wr = 1'b1;
    step();
    chk("fl_next", ibus_addr, 32'hBFC0_0384);

    // Misaligned branch target
    branch_taken = 1'b1; branch_target = 32'h8000_0002;
    step();
    branch_taken = 1'b0;
    chk("mis_pc",  PREIF_PC, 32'h8000_0002);
    chk("mis_exc", 32'(PREIF_ExceptType), 32'd1);
    chk("mis_req", 32'(ibus_req), 32'd0);
    ibus_addr_ok = 1'b0;
    step();
    chk("mis2_pc",  PREIF_PC, 32'h8000_0006);
    chk("mis2_exc", 32'(PREIF_ExceptType), 32'd1);
    chk("mis2_req", 32'(ibus_req), 32'd0);

    // Wrap-around from the top of the address space
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump_taken = 1'b0; ibus_addr_ok = 1'b1;
    chk("top_addr", ibus_addr, 32'hFFFF_FFFC);
    chk("top_req",  32'(ibus_req), 32'd1);
    step();
    chk("wrap_addr", ibus_addr, 32'h0000_0000);
    chk("wrap_exc",  32'(PREIF_ExceptType), 32'd0);

    // Branch and jump together on an advance: branch wins
    branch_taken = 1'b1; branch_target = 32'h8000_7000;
    jump_taken = 1'b1; jump_target = 32'h8000_8000;
    step();
    branch_taken = 1'b0; jump_taken = 1'b0;
    chk("bj_addr", ibus_addr, 32'h8000_7000);

    // Async reset in S_HOLD with a buffered redirect
    IF_Wr = 1'b0;
    step();
    chk("e_hold_req", 32'(ibus_req), 32'd0);
    ibus_addr_ok = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h8000_9000;
    step();
    branch_taken = 1'b0;
    chk("e_pend", 32'(dut.pend_v), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_pc",   PREIF_PC, 32'hBFC0_0000);
    chk("arst_req",  32'(ibus_req), 32'd0);
    chk("arst_pend", 32'(dut.pend_v), 32'd0);
    chk("arst_exc",  32'(PREIF_ExceptType), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
